// File: rtl/forward_scoreboard.sv
// Forwarding and load-use hazard unit for the LEGv8 pipeline: tracks destinations of
// instructions that left EX and derives per-operand bypass selects plus a load-use stall.
module forward_scoreboard #(
    parameter int NSTAGES     = 2,
    parameter int NSRC        = 2,
    parameter int REGADDRSIZE = 5,
    parameter int XZR         = 31,
    parameter int LOADLAT     = 2,
    parameter int SELW        = $clog2(NSTAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        advance,
    input  logic                        flush,
    input  logic                        ex_valid,
    input  logic                        ex_regwrite,
    input  logic                        ex_branch,
    input  logic                        ex_load,
    input  logic [REGADDRSIZE-1:0]      ex_rd,
    input  logic [NSRC*REGADDRSIZE-1:0] ex_src,
    input  logic [NSRC-1:0]             ex_srcuse,
    output logic [NSRC*SELW-1:0]        fwd_sel,
    output logic                        stall,
    output logic [15:0]                 stall_count
);

    typedef struct packed {
        logic                   valid;
        logic                   regwrite;
        logic                   branch;
        logic                   load;
        logic [REGADDRSIZE-1:0] rd;
    } tag_t;

    localparam logic [REGADDRSIZE-1:0] XZR_ADDR = REGADDRSIZE'(XZR);

    // Entry 1 is the instruction that left EX most recently.
    tag_t tags [1:NSTAGES];

    always_comb begin
        logic             hit;
        logic             early;
        logic [SELW-1:0]  hit_k;
        // NOTE: every combinational output and temporary gets a default before any
        // conditional assignment, otherwise synthesis infers latches.
        fwd_sel = '0;
        stall   = 1'b0;
        hit     = 1'b0;
        early   = 1'b0;
        hit_k   = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit   = 1'b0;
            early = 1'b0;
            hit_k = '0;
            // Scan oldest to youngest so the youngest producer overrides older ones.
            for (int k = NSTAGES; k >= 1; k--) begin
                if (tags[k].valid && tags[k].regwrite && !tags[k].branch &&
                    tags[k].rd != XZR_ADDR &&
                    tags[k].rd == ex_src[i*REGADDRSIZE +: REGADDRSIZE]) begin
                    hit   = 1'b1;
                    hit_k = SELW'(k);
                    early = tags[k].load && (k < LOADLAT);
                end
            end
            if (ex_srcuse[i] && hit) begin
                if (early) begin
                    stall = 1'b1;
                end else begin
                    fwd_sel[i*SELW +: SELW] = hit_k;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every entry shifts
    // from its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= NSTAGES; k++) begin
                tags[k] <= '0;
            end
            stall_count <= 16'd0;
        end else if (advance) begin
            for (int k = 2; k <= NSTAGES; k++) begin
                tags[k] <= tags[k-1];
            end
            if (stall) begin
                // The stalled instruction stays in EX; MEM receives a bubble.
                tags[1] <= '0;
                if (stall_count != 16'hFFFF) begin
                    stall_count <= stall_count + 16'd1;
                end
            end else begin
                tags[1] <= '{valid:    ex_valid && !flush,
                             regwrite: ex_regwrite,
                             branch:   ex_branch,
                             load:     ex_load,
                             rd:       ex_rd};
            end
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Self-checking bench for forward_scoreboard: a default instance plus a deeper
// NSTAGES=3/LOADLAT=3 instance sharing the same stimulus.
module tb_forward_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        advance, flush, ex_valid, ex_regwrite, ex_branch, ex_load;
    logic [4:0]  ex_rd;
    logic [9:0]  ex_src;
    logic [1:0]  ex_srcuse;
    logic [3:0]  fwd_sel, fwd_sel3;
    logic        stall, stall3;
    logic [15:0] stall_count, stall_count3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forward_scoreboard dut (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_src(ex_src), .ex_srcuse(ex_srcuse),
        .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
    );

    forward_scoreboard #(.NSTAGES(3), .LOADLAT(3)) dut3 (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_src(ex_src), .ex_srcuse(ex_srcuse),
        .fwd_sel(fwd_sel3), .stall(stall3), .stall_count(stall_count3)
    );

    typedef struct {
        string      name;
        logic       adv, fl, valid, rw, br, ld;
        logic [4:0] rd, s0, s1;
        logic [1:0] su;
        logic [1:0] e0, e1;
        logic       est;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] e0, e1;
        logic       est;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(string name, int adv, int fl, int valid, int rw, int br,
                                int ld, int rd, int s0, int s1, int su,
                                int e0, int e1, int est);
        vec_t v;
        v.name = name;
        v.adv = adv[0]; v.fl = fl[0]; v.valid = valid[0];
        v.rw = rw[0]; v.br = br[0]; v.ld = ld[0];
        v.rd = 5'(rd); v.s0 = 5'(s0); v.s1 = 5'(s1); v.su = 2'(su);
        v.e0 = 2'(e0); v.e1 = 2'(e1); v.est = est[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        advance     = v.adv;
        flush       = v.fl;
        ex_valid    = v.valid;
        ex_regwrite = v.rw;
        ex_branch   = v.br;
        ex_load     = v.ld;
        ex_rd       = v.rd;
        ex_src      = {v.s1, v.s0};
        ex_srcuse   = v.su;
    endtask

    // Drive just after the rising edge, then wait to the falling edge for sampling.
    task automatic cycle(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(mk("idle", 0,0,0,0,0,0, 0, 0,0, 0, 0,0,0));
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        vec_t ld3, rd3, rd3_hold;
        exp_t e;

        rst = 1'b1;
        drive(mk("idle", 0,0,0,0,0,0, 0, 0,0, 0, 0,0,0));
        #2;
        drive(mk("poke", 1,0,1,1,0,0, 3, 3,3, 3, 0,0,0));
        #1;
        check("reset_fwd_sel", 32'(fwd_sel), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_count", 32'(stall_count), 0);
        check("reset_count3", 32'(stall_count3), 0);
        drive(mk("idle", 0,0,0,0,0,0, 0, 0,0, 0, 0,0,0));
        #2;
        rst = 1'b0;

        //              name            adv fl v rw br ld rd  s0 s1 su  e0 e1 st
        tbl.push_back(mk("add_x1",        1,0,1,1,0,0,  1, 10,11, 3,  0,0,0));
        tbl.push_back(mk("sub_reads_x1",  1,0,1,1,0,0,  6,  1,12, 3,  1,0,0));
        tbl.push_back(mk("add_x2",        1,0,1,1,0,0,  2, 13,14, 3,  0,0,0));
        tbl.push_back(mk("orr_x7",        1,0,1,1,0,0,  7, 20,21, 3,  0,0,0));
        tbl.push_back(mk("read_x2_x7",    1,0,1,1,0,0,  8,  2, 7, 3,  2,1,0));
        tbl.push_back(mk("add_x2_old",    1,0,1,1,0,0,  2, 20,21, 3,  0,0,0));
        tbl.push_back(mk("add_x2_new",    1,0,1,1,0,0,  2,  2,22, 3,  1,0,0));
        tbl.push_back(mk("younger_wins",  1,0,1,1,0,0,  9,  2, 2, 3,  1,1,0));
        tbl.push_back(mk("srcuse_mask",   1,0,1,1,0,0, 10,  9, 2, 1,  1,0,0));
        tbl.push_back(mk("write_xzr",     1,0,1,1,0,0, 31,  0, 0, 0,  0,0,0));
        tbl.push_back(mk("flushed_x5",    1,1,1,1,0,0,  5,  0, 0, 0,  0,0,0));
        tbl.push_back(mk("read_xzr_x5",   1,0,1,1,0,0, 12, 31, 5, 3,  0,0,0));
        tbl.push_back(mk("branch_x4",     1,0,1,1,1,0,  4,  0, 0, 0,  0,0,0));
        tbl.push_back(mk("read_branch",   1,0,1,1,0,0, 13,  4, 4, 3,  0,0,0));
        tbl.push_back(mk("ldur_x3",       1,0,1,1,0,1,  3, 20, 0, 1,  0,0,0));
        tbl.push_back(mk("load_use",      1,0,1,1,0,0, 15,  3, 0, 3,  0,0,1));
        tbl.push_back(mk("load_fwd",      1,0,1,1,0,0, 15,  3, 0, 3,  2,0,0));
        tbl.push_back(mk("add_x3",        1,0,1,1,0,0,  3,  0, 0, 0,  0,0,0));
        tbl.push_back(mk("ldur_x3_b",     1,0,1,1,0,1,  3,  0, 0, 0,  0,0,0));
        tbl.push_back(mk("shadow_stall",  1,0,1,1,0,0, 16,  3, 0, 1,  0,0,1));
        tbl.push_back(mk("shadow_fwd",    1,0,1,1,0,0, 16,  3, 0, 1,  2,0,0));

        foreach (tbl[n]) begin
            @(posedge clk);
            #1;
            drive(tbl[n]);
            exp_q.push_back('{name: tbl[n].name, e0: tbl[n].e0, e1: tbl[n].e1, est: tbl[n].est});
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, ".sel0"}, 32'(fwd_sel[1:0]), 32'(e.e0));
                check({e.name, ".sel1"}, 32'(fwd_sel[3:2]), 32'(e.e1));
                check({e.name, ".stall"}, 32'(stall), 32'(e.est));
            end
        end
        check("table_stall_count", 32'(stall_count), 2);

        ld3      = mk("ldur_x3", 1,0,1,1,0,1, 3, 0,0, 0, 0,0,0);
        rd3      = mk("read_x3", 1,0,1,1,0,0, 5, 3,0, 1, 0,0,0);
        rd3_hold = mk("read_x3", 0,0,1,1,0,0, 5, 3,0, 1, 0,0,0);

        // Load-use latency for both depths.
        do_reset();
        cycle(ld3);
        cycle(rd3);
        check("lu.c1.stall", 32'(stall), 1);
        check("lu.c1.sel", 32'(fwd_sel), 0);
        check("lu3.c1.stall", 32'(stall3), 1);
        cycle(rd3);
        check("lu.c2.stall", 32'(stall), 0);
        check("lu.c2.sel0", 32'(fwd_sel[1:0]), 2);
        check("lu3.c2.stall", 32'(stall3), 1);
        check("lu3.c2.sel", 32'(fwd_sel3), 0);
        cycle(rd3);
        check("lu3.c3.stall", 32'(stall3), 0);
        check("lu3.c3.sel0", 32'(fwd_sel3[1:0]), 3);
        check("lu.count", 32'(stall_count), 1);
        check("lu3.count", 32'(stall_count3), 2);

        // Stall frozen by advance low.
        do_reset();
        cycle(ld3);
        for (int c = 0; c < 3; c++) begin
            cycle(rd3_hold);
            check("hold.stall", 32'(stall), 1);
            check("hold.count", 32'(stall_count), 0);
        end
        cycle(rd3);
        check("release.stall", 32'(stall), 1);
        cycle(rd3);
        check("release.after.stall", 32'(stall), 0);
        check("release.after.sel0", 32'(fwd_sel[1:0]), 2);
        check("release.count", 32'(stall_count), 1);

        // Asynchronous reset in the middle of a multi-cycle stall.
        do_reset();
        cycle(ld3);
        cycle(rd3);
        cycle(rd3);
        check("midrst.pre.stall3", 32'(stall3), 1);
        check("midrst.pre.count3", 32'(stall_count3), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.stall3", 32'(stall3), 0);
        check("midrst.sel3", 32'(fwd_sel3), 0);
        check("midrst.count3", 32'(stall_count3), 0);
        check("midrst.stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(rd3);
        check("postrst.sel", 32'(fwd_sel), 0);
        check("postrst.stall", 32'(stall), 0);
        check("postrst.sel3", 32'(fwd_sel3), 0);
        check("postrst.stall3", 32'(stall3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined LEGv8 core, sitting beside the ID/EX register. It records, in an internal tag pipeline, the destination of every instruction that leaves EX. From that record it produces per-operand bypass selects for the instruction in EX and a load-use stall that inserts bubbles until load data is forwardable. Per-entry valid bits replace the external fill `stage` counter of the previous forwarding unit. Depth, operand count and load latency are parameters.

## Interface
- `NSTAGES`, 2: forwardable stages after EX; entry 1 = EX/MEM, entry 2 = MEM/WB, …
- `NSRC`, 2: source operands checked per instruction.
- `REGADDRSIZE`, 5: register address width.
- `XZR`, 31: zero register address; never forwarded.
- `LOADLAT`, 2: lowest entry index at which load data is forwardable (1 ≤ LOADLAT ≤ NSTAGES).
- `SELW`, `$clog2(NSTAGES+1)`: select width (derived).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `advance`  in  1  global pipeline enable; low freezes all state.
- `flush`  in  1  EX instruction squashed; captured as a bubble.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_regwrite`  in  1  EX instruction writes `ex_rd`.
- `ex_branch`  in  1  EX instruction is a branch (never a forwarding source).
- `ex_load`  in  1  EX instruction is a load.
- `ex_rd`  in  REGADDRSIZE  EX destination.
- `ex_src`  in  NSRC*REGADDRSIZE  EX operand addresses; operand i at bits [i*REGADDRSIZE +: REGADDRSIZE].
- `ex_srcuse`  in  NSRC  operand i actually read.
- `fwd_sel`  out  NSRC*SELW  per operand: 0 = register file, k = entry k.
- `stall`  out  1  load-use hazard; hold PC/IF/ID/ID-EX and send a bubble to MEM.
- `stall_count`  out  16  saturating count of stall cycles taken.

## Operation
- Tag entry k (1..NSTAGES) = {valid, regwrite, branch, load, rd}.
- An entry is a producer when: valid, regwrite, !branch, rd != XZR.
- Operand i searches k = 1..NSTAGES in order. The lowest-k producer with rd == ex_src[i] is the match. Younger entries win.
- `fwd_sel[i]` = k if `ex_srcuse[i]` and a match exists and !(match.load && k < LOADLAT); otherwise 0.
- `stall` = OR over i of (`ex_srcuse[i]` && match.load && k < LOADLAT).
  - An older non-load match is never used when a younger load matches.
  - The selection shadowed by a stall is 0.
- Update priority:
  - `rst`: all entries invalid; `stall_count` = 0.
  - else `!advance`: hold everything.
  - else `stall`: entries shift k→k+1 (last entry discarded); entry 1 ← invalid bubble; EX contents are not captured.
  - else: shift; entry 1 ← {ex_valid && !flush, ex_regwrite, ex_branch, ex_load, ex_rd}.
- `stall_count` increments when `advance && stall`, saturating at 16'hFFFF.
- `flush` together with `stall`: stall path wins. The EX instruction stays in EX and the external pipeline squashes it.

## Timing
- `fwd_sel` and `stall` are combinational from entries plus `ex_*` inputs, so they are valid in the same cycle.
- Tag state changes one edge after capture.
- Reset values: `fwd_sel` = 0, `stall` = 0, `stall_count` = 0. Each is asserted asynchronously on `rst` rise.
- Load-use stall lasts LOADLAT−k cycles for a dependent at distance k. With defaults, an adjacent dependent gets 1 cycle.
- Reset mid-stall clears the stall immediately; the first cycle after release forwards nothing.
- `advance` low during a stall: `stall` stays asserted, no shift occurs, and `stall_count` does not increment.

## Test plan
- Reset, then `ADD X1` in EX, then `SUB` reading X1 as src0 with `advance`=1 → next cycle `fwd_sel[0]`=1, `stall`=0.
- `ADD X2` followed two cycles later by a reader of X2 → `fwd_sel`=2. With writers of X2 at entries 1 and 2 → `fwd_sel`=1.
- `LDUR X3` then an adjacent reader of X3 → `stall`=1 for one cycle with `fwd_sel`=0, then `fwd_sel`=2, and `stall_count`=1. Repeat with LOADLAT=3, NSTAGES=3 → 2 stall cycles, then `fwd_sel`=3, and `stall_count`=2.
- Writer to X31, branch with regwrite=1, and flushed writer to X4 → the following readers get `fwd_sel`=0.
- Load-use stall with `advance` held low for 3 cycles → `stall` stays 1, `stall_count` unchanged. Then release → one counted stall.
- Assert `rst` during a stall → `stall`=0 and `fwd_sel`=0 asynchronously, all entries invalid. A reader of the prior rd after release gets `fwd_sel`=0.
